id_ex_stage: RTL
================

# id_ex_stage

Decode-side pipeline stage directly downstream of the PC/IF-ID register. It consumes the registered ID instruction and PC+4, resolves conditional branches in ID, and detects load-use and branch-operand hazards. It drives `stall` and `isBranch`/`BranchDst` back to the fetch stage and registers the ID/EX pipeline bundle for the ALU stage, inserting bubbles on stall or flush.

## Interface
- No parameters; all widths are fixed by the MIPS-32 datapath.
- `clk` input 1: single clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-low; sampled low at a rising `clk` edge resets the block.
- `ID_Inst` input 32: instruction held in IF/ID.
- `ID_PC4` input 32: PC+4 of `ID_Inst`.
- `ID_RsData` input 32: register-file read data for `ID_Inst[25:21]`.
- `ID_RtData` input 32: register-file read data for `ID_Inst[20:16]`.
- `ID_Ctrl` input 12: control-unit bundle. Bit 0 RegWrite, bit 1 MemRead, bit 2 MemWrite, [4:3] MemtoReg, [6:5] RegDst, bit 7 ALUSrc, bit 8 ExtOp, bit 9 LuOp, [11:10] passed through unchanged.
- `flush` input 1: kills the ID instruction (exception or interrupt taken).
- `MEM_MemRead` input 1: the instruction in MEM is a load.
- `MEM_WriteReg` input 5: destination register of the instruction in MEM.
- `stall` output 1: combinational; holds PC and IF/ID.
- `isBranch` output 1: combinational; conditional branch in ID is taken.
- `BranchDst` output 32: combinational; `ID_PC4 + (sext(imm16) << 2)`, mod 2^32.
- `EX_PC4`, `EX_RsData`, `EX_RtData`, `EX_Imm` output 32 each: registered.
- `EX_Rs`, `EX_Rt`, `EX_WriteReg`, `EX_Shamt` output 5 each: registered.
- `EX_Funct`, `EX_Opcode` output 6 each: registered.
- `EX_Ctrl` output 12: registered control bundle.

## Operation
- **Immediate extension.**
  - LuOp=1: `EX_Imm = {imm16, 16'h0}`.
  - Otherwise ExtOp=1 sign-extends `imm16` and ExtOp=0 zero-extends it.
- **WriteReg selection by RegDst:** 00 selects rt, 01 selects rd, 10 selects 31 (jal/jalr), 11 selects 26 (exception return link).
- **Operand use.**
  - rs is used except for opcode 02/03, opcode 0F, and R-type funct 00/02/03.
  - rt is used for R-type (opcode 00) and opcodes 04, 05 and 2B.
  - Register 0 never causes a hazard.
- **Load-use hazard:** registered `EX_Ctrl` MemRead=1 and `EX_WriteReg` equals a used source register.
- **Branch hazard:** `ID_Inst` is a branch (opcode 01/04/05/06/07) and either condition holds:
  - EX RegWrite=1 and `EX_WriteReg` equals rs, or equals rt for 04/05;
  - `MEM_MemRead`=1 and `MEM_WriteReg` matches the same operands.
- **Outputs from the hazard checks.**
  - `stall` is asserted when either hazard is present.
  - `isBranch` is forced to 0 while `stall`=1.
- **Branch conditions** (signed where relevant):
  - 04 taken when rs == rt; 05 taken when rs != rt.
  - 06 taken when rs <= 0; 07 taken when rs > 0.
  - 01 with rt field 0 is bltz (rs < 0); with rt field 1 it is bgez (rs >= 0).
- **Register update priority, highest first:**
  - reset: all EX_* outputs cleared to 0.
  - flush: bubble (all EX_* = 0).
  - stall: bubble.
  - Otherwise ID fields and data are captured into EX_*.
- **Bubble definition:** `EX_Ctrl`=0 (no write, no memory access), `EX_WriteReg`=0, and all other EX_* = 0.
- `flush` does not gate `stall` or `isBranch`. The fetch stage prioritises PCSrc over both.

## Timing
- ID to EX latency: 1 cycle.
- `stall`, `isBranch` and `BranchDst` are combinational on the current `ID_Inst`, EX_* and MEM_* values.
- After reset all EX_* are 0. `stall` is then 0 unless `MEM_MemRead` matches a branch operand.
- Load-use: exactly 1 stall cycle. The load moves to MEM and the bubble in EX clears the condition.
- Branch behind a load:
  - 2 stall cycles: the load is in EX, then in MEM.
  - ALU producer in EX: 1 stall cycle.
- Simultaneous `flush` and `stall`: the bubble is registered; the flush takes effect.
- Reset asserted mid-stall: EX_* are 0 on the next edge and the stall ends.
- `BranchDst` wraps modulo 2^32. The fetch stage owns PC[31] preservation.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct constants (BEQ=04, BNE=05, BLEZ=06, BGTZ=07, REGIMM=01, LUI=0F, SW=2B, J=02, JAL=03);
  - `ID_Ctrl` bit-index constants;
  - RegDst encodings;
  - the bubble value constant.
- One sub-module, `hazard_unit`, is purely combinational. Its inputs are the ID rs, rt, opcode and funct, the EX MemRead, RegWrite and WriteReg, and `MEM_MemRead`/`MEM_WriteReg`. Its only output is `stall`.
- All other logic (extension, WriteReg mux, branch compare, ID/EX registers) sits in `id_ex_stage`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with arbitrary inputs, then release. All EX_* = 0 and `stall`=0.
- **Load-use:**
  - Stimulus: `lw $8,0($9)` followed by `add $10,$8,$11`.
  - Cycle after the lw is captured: `stall`=1.
  - Next edge: `EX_Ctrl`=0 and the add is still in ID.
  - Following edge: add captured, `EX_Rs`=8, `EX_WriteReg`=10.
- **Branch after ALU producer:**
  - Stimulus: `addi $4,$0,5`, then `beq $4,$5,+3` with ID_PC4=0x40 and both operands equal to 5.
  - 1 cycle of `stall`=1 with `isBranch`=0.
  - Next cycle: `isBranch`=1, `BranchDst`=0x4C.
- **Branch behind load:** `lw $4`, then `bgtz $4`. `stall`=1 for 2 consecutive cycles, then `isBranch` follows the sign of rs.
- **Flush with stall:** a load-use condition together with `flush`=1. Next EX_* = 0, then normal capture resumes.
- **Immediate and WriteReg:**
  - `lui $3,0x1234`: `EX_Imm`=0x12340000, `EX_WriteReg`=3.
  - `jal` (RegDst=10): `EX_WriteReg`=31.
  - `andi` with imm 0xFFFF (ExtOp=0): `EX_Imm`=0x0000FFFF.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS-32 decode constants, control-bundle bit indices,
//               RegDst encodings and the ID/EX pipeline bundle with its
//               bubble value.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] c_op_rtype  = 6'h00;
    localparam logic [5:0] c_op_regimm = 6'h01;
    localparam logic [5:0] c_op_j      = 6'h02;
    localparam logic [5:0] c_op_jal    = 6'h03;
    localparam logic [5:0] c_op_beq    = 6'h04;
    localparam logic [5:0] c_op_bne    = 6'h05;
    localparam logic [5:0] c_op_blez   = 6'h06;
    localparam logic [5:0] c_op_bgtz   = 6'h07;
    localparam logic [5:0] c_op_lui    = 6'h0F;
    localparam logic [5:0] c_op_sw     = 6'h2B;

    // R-type functs that take their operand from shamt instead of rs
    localparam logic [5:0] c_fn_sll = 6'h00;
    localparam logic [5:0] c_fn_srl = 6'h02;
    localparam logic [5:0] c_fn_sra = 6'h03;

    // REGIMM rt-field selectors
    localparam logic [4:0] c_rt_bltz = 5'd0;
    localparam logic [4:0] c_rt_bgez = 5'd1;

    // Bit positions inside the 12-bit control bundle
    localparam int c_ctrl_regwrite    = 0;
    localparam int c_ctrl_memread     = 1;
    localparam int c_ctrl_memwrite    = 2;
    localparam int c_ctrl_memtoreg_lo = 3;
    localparam int c_ctrl_regdst_lo   = 5;
    localparam int c_ctrl_alusrc      = 7;
    localparam int c_ctrl_extop       = 8;
    localparam int c_ctrl_luop        = 9;

    // RegDst encodings
    localparam logic [1:0] c_regdst_rt  = 2'b00;
    localparam logic [1:0] c_regdst_rd  = 2'b01;
    localparam logic [1:0] c_regdst_ra  = 2'b10;
    localparam logic [1:0] c_regdst_xlk = 2'b11;

    // Fixed link registers
    localparam logic [4:0] c_reg_ra  = 5'd31;
    localparam logic [4:0] c_reg_xlk = 5'd26;

    // ID/EX pipeline bundle
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  write_reg;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [5:0]  opcode;
        logic [11:0] ctrl;
    } id_ex_t;

    // A bubble carries no write and no memory access; everything is zero
    localparam id_ex_t c_bubble = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Combinational load-use and branch-operand hazard detection
//               for the instruction held in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import mips_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [5:0] id_opcode,
    input  logic [5:0] id_funct,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_write_reg,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_write_reg,
    output logic       stall
);

    logic w_rs_used;
    logic w_rt_used;
    logic w_is_branch;
    logic w_br_uses_rt;
    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;

    // Decode which source registers the ID instruction actually reads
    always_comb begin
        w_rs_used = 1'b1;
        if (id_opcode == c_op_j || id_opcode == c_op_jal || id_opcode == c_op_lui) begin
            w_rs_used = 1'b0;
        end else if (id_opcode == c_op_rtype &&
                     (id_funct == c_fn_sll || id_funct == c_fn_srl || id_funct == c_fn_sra)) begin
            w_rs_used = 1'b0;
        end
        w_rt_used    = (id_opcode == c_op_rtype) || (id_opcode == c_op_beq) ||
                       (id_opcode == c_op_bne)   || (id_opcode == c_op_sw);
        w_is_branch  = (id_opcode == c_op_regimm) || (id_opcode == c_op_beq) ||
                       (id_opcode == c_op_bne)    || (id_opcode == c_op_blez) ||
                       (id_opcode == c_op_bgtz);
        w_br_uses_rt = (id_opcode == c_op_beq) || (id_opcode == c_op_bne);
    end

    // Hazard terms; register 0 is hard-wired and never a real dependency
    always_comb begin
        w_load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
                     ((w_rs_used && ex_write_reg == id_rs) ||
                      (w_rt_used && ex_write_reg == id_rt));
        w_br_ex    = w_is_branch && ex_reg_write && (ex_write_reg != 5'd0) &&
                     ((ex_write_reg == id_rs) || (w_br_uses_rt && ex_write_reg == id_rt));
        w_br_mem   = w_is_branch && mem_mem_read && (mem_write_reg != 5'd0) &&
                     ((mem_write_reg == id_rs) || (w_br_uses_rt && mem_write_reg == id_rt));
        stall      = w_load_use || w_br_ex || w_br_mem;
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Decode stage: immediate extension, destination select,
//               branch resolution in ID, hazard stall generation and the
//               ID/EX pipeline register with bubble insertion.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ID_Inst,
    input  logic [31:0] ID_PC4,
    input  logic [31:0] ID_RsData,
    input  logic [31:0] ID_RtData,
    input  logic [11:0] ID_Ctrl,
    input  logic        flush,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_WriteReg,
    output logic        stall,
    output logic        isBranch,
    output logic [31:0] BranchDst,
    output logic [31:0] EX_PC4,
    output logic [31:0] EX_RsData,
    output logic [31:0] EX_RtData,
    output logic [31:0] EX_Imm,
    output logic [4:0]  EX_Rs,
    output logic [4:0]  EX_Rt,
    output logic [4:0]  EX_WriteReg,
    output logic [4:0]  EX_Shamt,
    output logic [5:0]  EX_Funct,
    output logic [5:0]  EX_Opcode,
    output logic [11:0] EX_Ctrl
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;
    logic [31:0] w_imm_ext;
    logic [4:0]  w_write_reg;
    logic        w_taken;
    logic        w_rs_neg;
    logic        w_rs_zero;
    logic        w_stall;
    id_ex_t      w_ex_next;
    id_ex_t      r_ex;

    assign w_opcode = ID_Inst[31:26];
    assign w_rs     = ID_Inst[25:21];
    assign w_rt     = ID_Inst[20:16];
    assign w_rd     = ID_Inst[15:11];
    assign w_shamt  = ID_Inst[10:6];
    assign w_funct  = ID_Inst[5:0];
    assign w_imm16  = ID_Inst[15:0];

    hazard_unit u_hazard (
        .id_rs         (w_rs),
        .id_rt         (w_rt),
        .id_opcode     (w_opcode),
        .id_funct      (w_funct),
        .ex_mem_read   (r_ex.ctrl[c_ctrl_memread]),
        .ex_reg_write  (r_ex.ctrl[c_ctrl_regwrite]),
        .ex_write_reg  (r_ex.write_reg),
        .mem_mem_read  (MEM_MemRead),
        .mem_write_reg (MEM_WriteReg),
        .stall         (w_stall)
    );

    // Immediate extension: LuOp takes precedence over ExtOp
    always_comb begin
        w_imm_ext = {16'h0000, w_imm16};
        if (ID_Ctrl[c_ctrl_luop]) begin
            w_imm_ext = {w_imm16, 16'h0000};
        end else if (ID_Ctrl[c_ctrl_extop]) begin
            w_imm_ext = {{16{w_imm16[15]}}, w_imm16};
        end
    end

    // Destination register select from RegDst
    always_comb begin
        w_write_reg = w_rt;
        case (ID_Ctrl[c_ctrl_regdst_lo +: 2])
            c_regdst_rt:  w_write_reg = w_rt;
            c_regdst_rd:  w_write_reg = w_rd;
            c_regdst_ra:  w_write_reg = c_reg_ra;
            c_regdst_xlk: w_write_reg = c_reg_xlk;
            default:      w_write_reg = w_rt;
        endcase
    end

    assign w_rs_neg  = ID_RsData[31];
    assign w_rs_zero = (ID_RsData == 32'h0);

    // Branch condition; signed tests reduce to sign bit and zero detect
    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            c_op_beq:    w_taken = (ID_RsData == ID_RtData);
            c_op_bne:    w_taken = (ID_RsData != ID_RtData);
            c_op_blez:   w_taken = w_rs_neg || w_rs_zero;
            c_op_bgtz:   w_taken = !w_rs_neg && !w_rs_zero;
            c_op_regimm: begin
                if (w_rt == c_rt_bltz) begin
                    w_taken = w_rs_neg;
                end else if (w_rt == c_rt_bgez) begin
                    w_taken = !w_rs_neg;
                end
            end
            default:     w_taken = 1'b0;
        endcase
    end

    // Target wraps naturally in 32 bits; PC[31] handling lives in fetch
    assign BranchDst = ID_PC4 + {{14{w_imm16[15]}}, w_imm16, 2'b00};
    assign stall     = w_stall;
    assign isBranch  = w_taken && !w_stall;

    // Assemble the bundle the ALU stage will see next cycle
    always_comb begin
        w_ex_next           = c_bubble;
        w_ex_next.pc4       = ID_PC4;
        w_ex_next.rs_data   = ID_RsData;
        w_ex_next.rt_data   = ID_RtData;
        w_ex_next.imm       = w_imm_ext;
        w_ex_next.rs        = w_rs;
        w_ex_next.rt        = w_rt;
        w_ex_next.write_reg = w_write_reg;
        w_ex_next.shamt     = w_shamt;
        w_ex_next.funct     = w_funct;
        w_ex_next.opcode    = w_opcode;
        w_ex_next.ctrl      = ID_Ctrl;
    end

    // ID/EX register: reset, then flush, then stall insert a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex <= c_bubble;
        end else if (flush || w_stall) begin
            r_ex <= c_bubble;
        end else begin
            r_ex <= w_ex_next;
        end
    end

    assign EX_PC4      = r_ex.pc4;
    assign EX_RsData   = r_ex.rs_data;
    assign EX_RtData   = r_ex.rt_data;
    assign EX_Imm      = r_ex.imm;
    assign EX_Rs       = r_ex.rs;
    assign EX_Rt       = r_ex.rt;
    assign EX_WriteReg = r_ex.write_reg;
    assign EX_Shamt    = r_ex.shamt;
    assign EX_Funct    = r_ex.funct;
    assign EX_Opcode   = r_ex.opcode;
    assign EX_Ctrl     = r_ex.ctrl;

endmodule
`default_nettype wire
